mem_stage: RTL and testbench

- Pipeline stage directly upstream of the write-back stage in the 16-bit core.
- Takes the execute-stage result and performs the data-memory access through a ready-based handshake. Stalls upstream while an access is outstanding.
- Registers ALUResult, StoreMem (load data), rdWB, RegWrite and RegStore for write-back.
- A watchdog aborts accesses that never complete.

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/mem_wb_reg.sv | 43 ++++
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the 16-bit core pipeline.
// Used by the memory stage and its write-back register.
package mem_stage_pkg;

  localparam int unsigned CORE_DATA_W = 16;
  localparam int unsigned CORE_REG_AW = 3;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// Write-back pipeline register with load, bubble and synchronous reset controls.
// A bubble clears only the write enable so downstream sees a harmless no-op.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = CORE_DATA_W,
  parameter int unsigned REG_AW = CORE_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              bubble,
  input  logic [DATA_W-1:0] next_alu_result,
  input  logic [DATA_W-1:0] next_store_mem,
  input  logic [REG_AW-1:0] next_rd,
  input  logic              next_reg_write,
  input  logic              next_reg_store,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_mem,
  output logic [REG_AW-1:0] rd,
  output logic              reg_write,
  output logic              reg_store
);

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result <= '0;
      store_mem  <= '0;
      rd         <= '0;
      reg_write  <= 1'b0;
      reg_store  <= 1'b0;
    end else if (load) begin
      alu_result <= next_alu_result;
      store_mem  <= next_store_mem;
      rd         <= next_rd;
      reg_write  <= next_reg_write;
      reg_store  <= next_reg_store;
    end else if (bubble) begin
      reg_write  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: ready-handshaked data-memory access feeding write-back,
// with upstream stall while waiting and a watchdog that drops hung accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = CORE_DATA_W,
  parameter int unsigned REG_AW  = CORE_REG_AW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_ALUResult,
  input  logic [DATA_W-1:0] ex_storeData,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_RegWrite,
  input  logic              ex_RegStore,
  input  logic              ex_MemRead,
  input  logic              ex_MemWrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              mem_stall,
  output logic              mem_fault,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] StoreMem,
  output logic [REG_AW-1:0] rdWB,
  output logic              RegWrite,
  output logic              RegStore
);

  localparam int unsigned CntW = 8;

  mem_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic              memop;
  logic              wb_load, wb_bubble;
  logic [DATA_W-1:0] wb_store_mem;

  assign memop      = ex_valid & (ex_MemRead | ex_MemWrite);
  assign dmem_we    = ex_MemWrite;
  assign dmem_addr  = ex_ALUResult;
  assign dmem_wdata = ex_storeData;
  assign mem_fault  = fault_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fault_d      = fault_q;
    dmem_req     = 1'b0;
    mem_stall    = 1'b0;
    wb_load      = 1'b0;
    wb_bubble    = 1'b0;
    wb_store_mem = ex_MemRead ? dmem_rdata : '0;

    unique case (state_q)
      StIdle: begin
        if (memop) begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            wb_load = 1'b1;
          end else begin
            mem_stall = 1'b1;
            wb_bubble = 1'b1;
            state_d   = StWait;
            cnt_d     = CntW'(1);
          end
        end else begin
          // Non-memory ops (and bubbles) pass straight through with no load data.
          wb_load      = 1'b1;
          wb_store_mem = '0;
        end
      end
      StWait: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          wb_load = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          // Abandon the access: release upstream so the instruction is dropped.
          fault_d   = 1'b1;
          wb_bubble = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
        end else begin
          mem_stall = 1'b1;
          wb_bubble = 1'b1;
          cnt_d     = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (reset) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_wb_reg (
    .clk             (clk),
    .reset           (reset),
    .load            (wb_load),
    .bubble          (wb_bubble),
    .next_alu_result (ex_ALUResult),
    .next_store_mem  (wb_store_mem),
    .next_rd         (ex_rd),
    .next_reg_write  (ex_valid & ex_RegWrite),
    .next_reg_store  (ex_RegStore),
    .alu_result      (ALUResult),
    .store_mem       (StoreMem),
    .rd              (rdWB),
    .reg_write       (RegWrite),
    .reg_store       (RegStore)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected write-back values are queued when
// stimulus is driven and popped for comparison after each clock edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [15:0] ex_ALUResult;
  logic [15:0] ex_storeData;
  logic [2:0]  ex_rd;
  logic        ex_RegWrite;
  logic        ex_RegStore;
  logic        ex_MemRead;
  logic        ex_MemWrite;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall;
  logic        mem_fault;
  logic [15:0] ALUResult;
  logic [15:0] StoreMem;
  logic [2:0]  rdWB;
  logic        RegWrite;
  logic        RegStore;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] sm;
    logic [2:0]  rd;
    logic        rw;
    logic        rs;
  } wb_t;

  wb_t exp_q[$];
  wb_t last_exp;
  int  tests  = 0;
  int  failed = 0;

  mem_stage #(
    .DATA_W  (16),
    .REG_AW  (3),
    .TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_ALUResult (ex_ALUResult),
    .ex_storeData (ex_storeData),
    .ex_rd        (ex_rd),
    .ex_RegWrite  (ex_RegWrite),
    .ex_RegStore  (ex_RegStore),
    .ex_MemRead   (ex_MemRead),
    .ex_MemWrite  (ex_MemWrite),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ready   (dmem_ready),
    .mem_stall    (mem_stall),
    .mem_fault    (mem_fault),
    .ALUResult    (ALUResult),
    .StoreMem     (StoreMem),
    .rdWB         (rdWB),
    .RegWrite     (RegWrite),
    .RegStore     (RegStore)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] alu, input logic [15:0] sm, input logic [2:0] rd,
                          input logic rw, input logic rs);
    wb_t e;
    e = '{alu: alu, sm: sm, rd: rd, rw: rw, rs: rs};
    exp_q.push_back(e);
    last_exp = e;
  endtask

  // Stalled/dropped edges: previous write-back values hold, write enable clears.
  task automatic push_bubble();
    push_exp(last_exp.alu, last_exp.sm, last_exp.rd, 1'b0, last_exp.rs);
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL %s_empty observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_alu"}, 32'(ALUResult), 32'(e.alu));
      check({tag, "_sm"},  32'(StoreMem),  32'(e.sm));
      check({tag, "_rd"},  32'(rdWB),      32'(e.rd));
      check({tag, "_rw"},  32'(RegWrite),  32'(e.rw));
      check({tag, "_rs"},  32'(RegStore),  32'(e.rs));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] wd,
                       input logic [2:0] rd, input logic rw, input logic rs,
                       input logic mr, input logic mw);
    ex_valid = v; ex_ALUResult = alu; ex_storeData = wd; ex_rd = rd;
    ex_RegWrite = rw; ex_RegStore = rs; ex_MemRead = mr; ex_MemWrite = mw;
  endtask

  initial begin
    // 1: reset with every input active
    reset = 1'b1;
    drive(1'b1, 16'hFFFF, 16'hFFFF, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    dmem_rdata = 16'hFFFF;
    dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_stall", 32'(mem_stall), 32'd0);
    end
    push_exp(16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    check_wb("rst_wb");
    check("rst_fault", 32'(mem_fault), 32'd0);

    // 2: plain ALU op, ready ignored without a request
    reset = 1'b0;
    drive(1'b1, 16'hAAAA, 16'h0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    dmem_ready = 1'b0;
    #1;
    check("alu_req", 32'(dmem_req), 32'd0);
    check("alu_stall", 32'(mem_stall), 32'd0);
    push_exp(16'hAAAA, 16'h0, 3'd5, 1'b1, 1'b1);
    tick();
    check_wb("alu_wb");

    // 3: two back-to-back loads with ready high
    drive(1'b1, 16'h0040, 16'h0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    dmem_rdata = 16'hBBBB;
    dmem_ready = 1'b1;
    #1;
    check("ld1_req", 32'(dmem_req), 32'd1);
    check("ld1_we", 32'(dmem_we), 32'd0);
    check("ld1_addr", 32'(dmem_addr), 32'h0040);
    check("ld1_stall", 32'(mem_stall), 32'd0);
    push_exp(16'h0040, 16'hBBBB, 3'd3, 1'b1, 1'b0);
    tick();
    check_wb("ld1_wb");
    drive(1'b1, 16'h0042, 16'h0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    dmem_rdata = 16'hCCCC;
    #1;
    check("ld2_stall", 32'(mem_stall), 32'd0);
    push_exp(16'h0042, 16'hCCCC, 3'd4, 1'b1, 1'b0);
    tick();
    check_wb("ld2_wb");

    // 4: store completing after three stalled cycles
    drive(1'b1, 16'h0010, 16'h1234, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_stall", 32'(mem_stall), 32'd1);
      check("st_req", 32'(dmem_req), 32'd1);
      check("st_we", 32'(dmem_we), 32'd1);
      check("st_wdata", 32'(dmem_wdata), 32'h1234);
      push_bubble();
      tick();
      check_wb("st_bubble");
    end
    dmem_ready = 1'b1;
    #1;
    check("st_done_stall", 32'(mem_stall), 32'd0);
    check("st_done_we", 32'(dmem_we), 32'd1);
    push_exp(16'h0010, 16'h0, 3'd2, 1'b0, 1'b0);
    tick();
    check_wb("st_wb");

    // 5: load that never completes trips the watchdog
    drive(1'b1, 16'h0050, 16'h0, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    dmem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("to_stall", 32'(mem_stall), 32'd1);
      check("to_fault_lo", 32'(mem_fault), 32'd0);
      push_bubble();
      tick();
      check_wb("to_bubble");
    end
    #1;
    check("to_drop_stall", 32'(mem_stall), 32'd0);
    push_bubble();
    tick();
    check_wb("to_drop");
    check("to_fault_hi", 32'(mem_fault), 32'd1);
    drive(1'b1, 16'h5555, 16'h0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("to_next_stall", 32'(mem_stall), 32'd0);
    push_exp(16'h5555, 16'h0, 3'd7, 1'b1, 1'b0);
    tick();
    check_wb("to_next_wb");
    check("to_fault_sticky", 32'(mem_fault), 32'd1);

    // 6: reset during the second wait cycle of a load
    drive(1'b1, 16'h0060, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    dmem_ready = 1'b0;
    push_bubble();
    tick();
    check_wb("rw_bubble");
    tick();
    reset = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 16'hDDDD;
    #1;
    check("rw_req", 32'(dmem_req), 32'd0);
    check("rw_stall", 32'(mem_stall), 32'd0);
    push_exp(16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    tick();
    check_wb("rw_rst_wb");
    check("rw_fault_clr", 32'(mem_fault), 32'd0);
    reset = 1'b0;
    drive(1'b0, 16'h7777, 16'h0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("rw_idle_req", 32'(dmem_req), 32'd0);
    check("rw_idle_stall", 32'(mem_stall), 32'd0);
    push_exp(16'h7777, 16'h0, 3'd2, 1'b0, 1'b1);
    tick();
    check_wb("rw_idle_wb");

    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
